// File: rtl/eth_tx_fcs_ctrl.sv
// MII nibble transmitter: preamble/SFD framing, minimum-length padding,
// CRC-32 FCS append, inter-frame gap and source-underrun abort.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for in_valid, nothing driven
// PREAMBLE | PREAMBLE_NIB nibbles of 0x5
// SFD      | one 0xD nibble, CRC seeded, length counter cleared
// DATA     | pass accepted source nibbles through, fold into CRC
// PAD      | 0x0 nibbles until minimum, even length is reached
// FCS      | eight nibbles of the inverted CRC, low nibble first
// IFG      | IFG_NIB quiet nibble times before returning to IDLE
module eth_tx_fcs_ctrl #(
  parameter int PREAMBLE_NIB = 15,
  parameter int MIN_NIB      = 120,
  parameter int IFG_NIB      = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [3:0] in_data,
  input  logic       in_last,
  output logic       in_ready,
  output logic       tx_en,
  output logic [3:0] txd,
  output logic       tx_er,
  output logic       busy,
  output logic       frame_done,
  output logic       underrun
);

  localparam int TW = 16;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_PREAMBLE = 3'd1;
  localparam logic [2:0] S_SFD      = 3'd2;
  localparam logic [2:0] S_DATA     = 3'd3;
  localparam logic [2:0] S_PAD      = 3'd4;
  localparam logic [2:0] S_FCS      = 3'd5;
  localparam logic [2:0] S_IFG      = 3'd6;

  logic [2:0]    r_state;
  logic [TW-1:0] r_tmr;
  logic [11:0]   r_cnt;
  logic          r_odd;
  logic [31:0]   r_crc;
  logic          r_tx_en;
  logic          r_tx_er;
  logic [3:0]    r_txd;
  logic          r_frame_done;
  logic          r_underrun;

  logic [3:0]  w_crc_in;
  logic [31:0] w_crc_next;
  logic [11:0] w_cnt_inc;
  logic        w_len_ok;
  logic [31:0] w_fcs;
  logic [2:0]  w_fcs_idx;
  logic [3:0]  w_fcs_nib;

  function automatic logic [31:0] crc_nib(input logic [31:0] c, input logic [3:0] d);
    logic [31:0] v;
    logic        fb;
    v = c;
    for (int i = 0; i < 4; i++) begin
      fb = v[0] ^ d[i];
      v  = v >> 1;
      if (fb) v = v ^ 32'hEDB88320;
    end
    return v;
  endfunction

  assign w_crc_in   = (r_state == S_DATA) ? in_data : 4'h0;
  assign w_crc_next = crc_nib(r_crc, w_crc_in);
  assign w_cnt_inc  = (r_cnt == 12'hFFF) ? r_cnt : r_cnt + 12'd1;
  // r_odd tracks true parity so a saturated counter cannot trap the frame in PAD
  assign w_len_ok   = (w_cnt_inc >= 12'(MIN_NIB)) && r_odd;
  assign w_fcs      = ~r_crc;
  assign w_fcs_idx  = 3'd7 - r_tmr[2:0];
  assign w_fcs_nib  = w_fcs[{w_fcs_idx, 2'b00} +: 4];

  assign in_ready   = (r_state == S_DATA);
  assign busy       = (r_state != S_IDLE);
  assign tx_en      = r_tx_en;
  assign tx_er      = r_tx_er;
  assign txd        = r_txd;
  assign frame_done = r_frame_done;
  assign underrun   = r_underrun;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_tmr        <= '0;
      r_cnt        <= '0;
      r_odd        <= 1'b0;
      r_crc        <= 32'hFFFFFFFF;
      r_tx_en      <= 1'b0;
      r_tx_er      <= 1'b0;
      r_txd        <= 4'h0;
      r_frame_done <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      r_tx_en      <= 1'b0;
      r_tx_er      <= 1'b0;
      r_txd        <= 4'h0;
      r_frame_done <= 1'b0;
      r_underrun   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_state <= S_PREAMBLE;
            r_tmr   <= TW'(PREAMBLE_NIB - 1);
          end
        end
        S_PREAMBLE: begin
          r_tx_en <= 1'b1;
          r_txd   <= 4'h5;
          if (r_tmr == '0) r_state <= S_SFD;
          else             r_tmr   <= r_tmr - 1'b1;
        end
        S_SFD: begin
          r_tx_en <= 1'b1;
          r_txd   <= 4'hD;
          r_crc   <= 32'hFFFFFFFF;
          r_cnt   <= '0;
          r_odd   <= 1'b0;
          r_state <= S_DATA;
        end
        S_DATA: begin
          r_tx_en <= 1'b1;
          if (in_valid) begin
            r_txd <= in_data;
            r_crc <= w_crc_next;
            r_cnt <= w_cnt_inc;
            r_odd <= ~r_odd;
            if (in_last) begin
              if (w_len_ok) begin
                r_state <= S_FCS;
                r_tmr   <= TW'(7);
              end else begin
                r_state <= S_PAD;
              end
            end
          end else begin
            r_tx_er    <= 1'b1;
            r_underrun <= 1'b1;
            r_state    <= S_IFG;
            r_tmr      <= TW'(IFG_NIB - 1);
          end
        end
        S_PAD: begin
          r_tx_en <= 1'b1;
          r_crc   <= w_crc_next;
          r_cnt   <= w_cnt_inc;
          r_odd   <= ~r_odd;
          if (w_len_ok) begin
            r_state <= S_FCS;
            r_tmr   <= TW'(7);
          end
        end
        S_FCS: begin
          r_tx_en <= 1'b1;
          r_txd   <= w_fcs_nib;
          if (r_tmr == '0) begin
            r_frame_done <= 1'b1;
            r_state      <= S_IFG;
            r_tmr        <= TW'(IFG_NIB - 1);
          end else begin
            r_tmr <= r_tmr - 1'b1;
          end
        end
        S_IFG: begin
          if (r_tmr == '0) r_state <= S_IDLE;
          else             r_tmr   <= r_tmr - 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_tx_fcs_ctrl.sv
// Scoreboard bench for eth_tx_fcs_ctrl: expected MII symbols are queued per
// frame from a byte-level CRC-32 model; a monitor pops them as tx_en shows.
module tb_eth_tx_fcs_ctrl;

  localparam int PRE = 15;
  localparam int MIN = 120;
  localparam int IFG = 24;

  typedef struct packed {
    logic       er;
    logic [3:0] d;
    logic       done;
    logic       ur;
    logic       g;
  } sym_t;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_last;
  logic       in_ready;
  logic       tx_en;
  logic [3:0] txd;
  logic       tx_er;
  logic       busy;
  logic       frame_done;
  logic       underrun;

  int   checks;
  int   failures;
  sym_t exp_q[$];

  eth_tx_fcs_ctrl #(.PREAMBLE_NIB(PRE), .MIN_NIB(MIN), .IFG_NIB(IFG)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .tx_en(tx_en), .txd(txd),
    .tx_er(tx_er), .busy(busy), .frame_done(frame_done), .underrun(underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm, input logic [31:0] got);
    checks++;
    failures++;
    $display("FAIL %s got=%0h exp=none t=%0t", nm, got, $time);
  endtask

  function automatic sym_t mk(input logic er, input logic [3:0] d, input logic done,
                              input logic ur, input logic g);
    sym_t s;
    s.er = er; s.d = d; s.done = done; s.ur = ur; s.g = g;
    return s;
  endfunction

  // Reflected CRC-32 register over bytes built from nibble pairs (low nibble first)
  function automatic logic [31:0] crc_reg(input logic [3:0] q[$], input int start);
    logic [31:0] c;
    logic [7:0]  b;
    c = 32'hFFFFFFFF;
    for (int k = start; k + 1 < q.size(); k += 2) begin
      b = {q[k+1], q[k]};
      c = c ^ {24'h0, b};
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  task automatic monitor();
    sym_t        e;
    int          ifg_cnt = -1;
    int          low_cnt = 0;
    int          rdy_cnt = 0;
    bit          arm = 0;
    logic [3:0]  rx_q[$];
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rx_q.delete();
        ifg_cnt = -1; arm = 0; low_cnt = 0; rdy_cnt = 0;
      end else begin
        if (ifg_cnt >= 0) begin
          ifg_cnt++;
          if (!busy) begin
            chk("ifg_len", ifg_cnt, IFG);
            ifg_cnt = -1;
          end else if (ifg_cnt > 200) begin
            fail_now("ifg_timeout", ifg_cnt);
            ifg_cnt = -1;
          end
        end
        if (tx_en) begin
          if (arm) begin
            chk("b2b_gap", low_cnt, IFG + 1);
            chk("b2b_ready", rdy_cnt, 0);
            arm = 0;
          end
          low_cnt = 0; rdy_cnt = 0;
          e = '0;
          if (exp_q.size() == 0) fail_now("extra_sym", {tx_er, txd, frame_done, underrun});
          else begin
            e = exp_q.pop_front();
            chk("tx_sym", {tx_er, txd, frame_done, underrun}, {e.er, e.d, e.done, e.ur});
          end
          rx_q.push_back(txd);
          if (frame_done) begin
            chk("residue", crc_reg(rx_q, PRE + 1), 32'hDEBB20E3);
            rx_q.delete();
            ifg_cnt = 0;
            arm = e.g;
          end
          if (underrun) begin
            rx_q.delete();
            ifg_cnt = 0;
          end
        end else begin
          low_cnt++;
          if (in_ready) rdy_cnt++;
          chk("idle_out", {tx_er, txd, frame_done, underrun}, 0);
        end
      end
    end
  endtask

  task automatic send_frame(input int n, input bit zero, input int ur_at, input int rst_at,
                            input bit keep, input bit gap);
    logic [3:0]  nibs[$];
    logic [3:0]  fr[$];
    logic [31:0] fcs;
    int          tot;
    int          i;
    int          wc;
    bit          done;
    for (int k = 0; k < n; k++) nibs.push_back(zero ? 4'h0 : 4'($urandom_range(0, 15)));
    for (int k = 0; k < PRE; k++) exp_q.push_back(mk(0, 4'h5, 0, 0, 0));
    exp_q.push_back(mk(0, 4'hD, 0, 0, 0));
    if (ur_at >= 0) begin
      for (int k = 0; k < ur_at; k++) exp_q.push_back(mk(0, nibs[k], 0, 0, 0));
      exp_q.push_back(mk(1, 4'h0, 0, 1, 0));
    end else begin
      fr  = nibs;
      tot = (n < MIN) ? MIN : n;
      if (tot % 2 != 0) tot++;
      while (fr.size() < tot) fr.push_back(4'h0);
      foreach (fr[k]) exp_q.push_back(mk(0, fr[k], 0, 0, 0));
      fcs = ~crc_reg(fr, 0);
      for (int k = 0; k < 8; k++) exp_q.push_back(mk(0, fcs[4*k +: 4], k == 7, 0, (k == 7) && gap));
    end
    i = 0; wc = 0; done = 0;
    while (!done) begin
      @(negedge clk);
      wc++;
      if (wc > 6000) begin
        fail_now("drive_timeout", i);
        done = 1;
      end else if (in_ready && i == rst_at) begin
        #2 rst_n = 1'b0;
        #1 chk("rst_async", {tx_en, tx_er, txd, in_ready, busy, frame_done, underrun}, 0);
        exp_q.delete();
        in_valid = 1'b0; in_last = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        return;
      end else if (in_ready && i == ur_at) begin
        in_valid = 1'b0; in_last = 1'b0;
        done = 1;
      end else begin
        in_valid = 1'b1;
        in_data  = nibs[i];
        in_last  = (i == n - 1);
        if (in_ready) i++;
        if (i == n) done = 1;
      end
    end
    if (!keep) begin
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0;
      wc = 0;
      while (busy && wc < 3000) begin
        @(negedge clk);
        wc++;
      end
      if (busy) fail_now("idle_timeout", wc);
      repeat (2) @(negedge clk);
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_data = 4'h0; in_last = 1'b0;
    #23;
    chk("reset_out", {tx_en, tx_er, txd, frame_done, underrun}, 0);
    chk("reset_ready_busy", {in_ready, busy}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    fork
      monitor();
    join_none
    repeat (2) @(negedge clk);

    send_frame(2, 1, -1, -1, 0, 0);
    send_frame(128, 0, -1, -1, 0, 0);
    send_frame(131, 0, -1, -1, 0, 0);
    send_frame(100, 0, 40, -1, 0, 0);
    send_frame($urandom_range(2, 200), 0, -1, -1, 1, 1);
    send_frame($urandom_range(2, 200), 0, -1, -1, 1, 1);
    send_frame($urandom_range(2, 200), 0, -1, -1, 0, 0);
    send_frame(150, 0, -1, 50, 0, 0);
    chk("post_reset_idle", {tx_en, busy, in_ready}, 0);
    send_frame(90, 0, -1, -1, 0, 0);
    for (int f = 0; f < 4; f++) send_frame($urandom_range(2, 260), 0, -1, -1, 0, 0);
    send_frame(300, 0, -1, -1, 0, 0);

    repeat (5) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    disable fork;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
